// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer row fetcher.
//   fb_state_e   : fetch FSM state encoding (IDLE / REQ / WAIT)
//   FB_LINES     : height of the bitmap area in screen lines
//   FB_LAST_LINE : last line of the frame; the first row fetch of a frame
//                  is launched there
//   FB_CNT_W     : width of the underrun counter
// -----------------------------------------------------------------------------
package fb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fb_state_e;

    localparam int FB_LINES     = 384;
    localparam int FB_LAST_LINE = 524;
    localparam int FB_CNT_W     = 16;

    // Width of a counter that must index 'n' items; never returns 0 so a
    // degenerate configuration still yields a legal vector.
    function automatic int fb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : fb_pkg

// File: rtl/fb_line_buf.sv
// -----------------------------------------------------------------------------
// fb_line_buf
// Two line banks of WPL words each. One synchronous write port used by the
// fetch engine, one combinational read port used by the pixel path. The
// storage has no reset: validity is tracked by the owner of this buffer.
//
// Ports
//   clk_i    : clock
//   we_i     : write enable
//   wbank_i  : bank written
//   waddr_i  : word index written
//   wdata_i  : write data
//   rbank_i  : bank read
//   raddr_i  : word index read
//   rdata_o  : read data (combinational), 0 for an index beyond WPL-1
// -----------------------------------------------------------------------------
module fb_line_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int WPL        = 8,
    parameter int WORD_W     = 3
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic                  wbank_i,
    input  logic [WORD_W-1:0]     waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  rbank_i,
    input  logic [WORD_W-1:0]     raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2][WPL];

    logic wr_in_range;
    logic rd_in_range;

    // The index vectors can address more than WPL words when WPL is not a
    // power of two; such accesses are dropped / read as zero.
    assign wr_in_range = (32'(waddr_i) < WPL);
    assign rd_in_range = (32'(raddr_i) < WPL);

    always_ff @(posedge clk_i) begin
        if (we_i && wr_in_range) begin
            mem_q[wbank_i][waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = rd_in_range ? mem_q[rbank_i][raddr_i] : '0;

endmodule : fb_line_buf

// File: rtl/fb_fetch.sv
// -----------------------------------------------------------------------------
// fb_fetch
// Fetches framebuffer rows from word-addressed memory into a two-bank line
// buffer, one row ahead of the raster, and serves the word covering the
// current pixel combinationally.
//
// Geometry (derived from parameters)
//   PPW  = 2^(clog2(DATA_WIDTH) + BITS_PER_MEMORY_PIXEL_X) screen pixels/word
//   WPL  = HEX_START_X / PPW                                words per row
//   ROWS = 384 >> BITS_PER_MEMORY_PIXEL_Y                  memory rows
//   Memory row r lives in bank r[0].
//
// Ports
//   CLK_50       : clock
//   reset        : asynchronous, active-high reset
//   pixel_x/y    : raster position from the sync generator
//   pixel_out    : word covering (pixel_x, pixel_y), 0 outside the bitmap
//                  or while the selected bank is not valid
//   mem_req      : read request
//   mem_addr     : read word address (0 whenever mem_req is low)
//   mem_gnt      : request accepted
//   mem_rvalid   : read data valid
//   mem_rdata    : read data
//   underrun_cnt : saturating count of row triggers that hit a busy fetcher
//
// Memory handshake: mem_req/mem_addr are raised in REQ and held unchanged
// until a cycle with mem_gnt high; that cycle transfers the request and the
// FSM moves to WAIT. Exactly one request is outstanding at a time. The
// response is the first cycle in WAIT with mem_rvalid high; mem_rvalid seen
// in IDLE or REQ is not a response and is dropped.
//
// Configuration
//   FB_FETCH_UNDERRUN_EN : when defined, underrun_cnt counts; otherwise it is
//                          tied to 0 and no counter is built.
// -----------------------------------------------------------------------------
module fb_fetch
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH              = 16,
    parameter int BITS_PER_MEMORY_PIXEL_X = 2,
    parameter int BITS_PER_MEMORY_PIXEL_Y = 3,
    parameter int HEX_START_X             = 512,
    parameter int ADDR_WIDTH              = 12,
    parameter int FB_BASE_ADDR            = 0
) (
    input  logic                  CLK_50,
    input  logic                  reset,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [FB_CNT_W-1:0]   underrun_cnt
);

    localparam int PPW_LOG2 = $clog2(DATA_WIDTH) + BITS_PER_MEMORY_PIXEL_X;
    localparam int PPW      = 1 << PPW_LOG2;
    localparam int WPL      = HEX_START_X / PPW;
    localparam int ROWS     = FB_LINES >> BITS_PER_MEMORY_PIXEL_Y;
    localparam int ROW_W    = fb_idx_w(ROWS);
    localparam int WORD_W   = fb_idx_w(WPL);

    localparam logic [9:0]        Y_MASK    = 10'((1 << BITS_PER_MEMORY_PIXEL_Y) - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WPL - 1);

    // -------------------------------------------------------------------------
    // Raster decode and fetch trigger
    // -------------------------------------------------------------------------
    logic [9:0]       scr_row;      // memory row under the current line
    logic             y_aligned;    // first screen line of a memory row
    logic             trig_first;   // end of frame: preload row 0
    logic             trig_next;    // start of row r: prefetch row r+1
    logic             trigger;
    logic [ROW_W-1:0] trig_row;

    assign scr_row    = pixel_y >> BITS_PER_MEMORY_PIXEL_Y;
    assign y_aligned  = ((pixel_y & Y_MASK) == '0);
    assign trig_first = (pixel_x == '0) && (pixel_y == 10'(FB_LAST_LINE));
    assign trig_next  = (pixel_x == '0)
                     && (32'(pixel_y) < FB_LINES)
                     && y_aligned
                     && ((32'(scr_row) + 32'd1) < 32'(ROWS));
    assign trigger    = trig_first || trig_next;
    assign trig_row   = trig_first ? '0 : ROW_W'(scr_row + 10'd1);

    // -------------------------------------------------------------------------
    // Fetch FSM
    // -------------------------------------------------------------------------
    fb_state_e        state_q, state_d;
    logic [ROW_W-1:0] row_q,   row_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]       valid_q, valid_d;
    logic             buf_we;

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            word_q  <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            word_q  <= word_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        word_d  = word_q;
        valid_d = valid_q;
        buf_we  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A bank being refilled must not be shown with a mix of
                // old and new words, so its flag drops at the trigger.
                if (trigger) begin
                    state_d             = ST_REQ;
                    row_d               = trig_row;
                    word_d              = '0;
                    valid_d[trig_row[0]] = 1'b0;
                end
            end

            ST_REQ: begin
                if (mem_gnt) begin
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (mem_rvalid) begin
                    buf_we = 1'b1;
                    if (word_q == LAST_WORD) begin
                        state_d           = ST_IDLE;
                        valid_d[row_q[0]] = 1'b1;
                    end else begin
                        state_d = ST_REQ;
                        word_d  = word_q + WORD_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Memory request; the sum wraps at ADDR_WIDTH bits by construction
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] addr_calc;

    assign addr_calc = ADDR_WIDTH'(FB_BASE_ADDR)
                     + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(WPL)
                     + ADDR_WIDTH'(word_q);

    assign mem_req  = (state_q == ST_REQ);
    assign mem_addr = mem_req ? addr_calc : '0;

    // -------------------------------------------------------------------------
    // Line buffer and pixel path
    // -------------------------------------------------------------------------
    logic                  rd_bank;
    logic [WORD_W-1:0]     rd_word;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  in_bitmap;

    assign rd_bank   = scr_row[0];
    assign rd_word   = WORD_W'(pixel_x >> PPW_LOG2);
    assign in_bitmap = (32'(pixel_x) < HEX_START_X) && (32'(pixel_y) < FB_LINES);

    fb_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .WPL        (WPL),
        .WORD_W     (WORD_W)
    ) u_line_buf (
        .clk_i   (CLK_50),
        .we_i    (buf_we),
        .wbank_i (row_q[0]),
        .waddr_i (word_q),
        .wdata_i (mem_rdata),
        .rbank_i (rd_bank),
        .raddr_i (rd_word),
        .rdata_o (rd_data)
    );

    assign pixel_out = (in_bitmap && valid_q[rd_bank]) ? rd_data : '0;

    // -------------------------------------------------------------------------
    // Underrun counter: a trigger while a fetch is still running means the
    // memory is too slow for the raster; that trigger is dropped.
    // -------------------------------------------------------------------------
`ifdef FB_FETCH_UNDERRUN_EN
    logic [FB_CNT_W-1:0] underrun_q, underrun_d;
    logic                underrun_evt;

    assign underrun_evt = trigger && (state_q != ST_IDLE);

    always_comb begin
        underrun_d = underrun_q;
        if (underrun_evt && (underrun_q != '1)) begin
            underrun_d = underrun_q + FB_CNT_W'(1);
        end
    end

    always_ff @(posedge CLK_50 or posedge reset) begin
        if (reset) begin
            underrun_q <= '0;
        end else begin
            underrun_q <= underrun_d;
        end
    end

    assign underrun_cnt = underrun_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule : fb_fetch

// File: tb/tb_fb_fetch.sv
// -----------------------------------------------------------------------------
// tb_fb_fetch
// Directed bench for fb_fetch at default parameters (PPW=64, WPL=8, ROWS=48).
// Memory model: word at address a holds 16'hA000 | a; mem_gnt and mem_rvalid
// are answered after gnt_lat / rv_lat cycles.
// -----------------------------------------------------------------------------
module tb_fb_fetch;

    logic        clk;
    logic        reset;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic [15:0] pixel_out;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [15:0] underrun_cnt;

    int n_cmp = 0;
    int n_err = 0;

    int gnt_lat  = 2;
    int rv_lat   = 2;
    int n_gnt    = 0;
    int n_rv     = 0;
    int hold_err = 0;

    logic [11:0] got_q[$];
    logic [11:0] exp_q[$];

    fb_fetch dut (
        .CLK_50       (clk),
        .reset        (reset),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .pixel_out    (pixel_out),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .underrun_cnt (underrun_cnt)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // ---------------- memory model ----------------
    initial begin
        logic [11:0] req_addr;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                req_addr = mem_addr;
                for (int i = 1; i < gnt_lat; i++) begin
                    @(negedge clk);
                    if (!mem_req || (mem_addr != req_addr)) hold_err++;
                end
                mem_gnt = 1'b1;
                got_q.push_back(req_addr);
                n_gnt++;
                @(negedge clk);
                mem_gnt = 1'b0;
                for (int i = 1; i < rv_lat; i++) @(negedge clk);
                mem_rvalid = 1'b1;
                mem_rdata  = 16'hA000 | 16'(req_addr);
                n_rv++;
                @(negedge clk);
                mem_rvalid = 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_row(input int row);
        for (int w = 0; w < 8; w++) exp_q.push_back(12'(row * 8 + w));
    endtask

    task automatic check_addrs(input string tag);
        check_eq({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            check_eq(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic fire(input int y);
        @(negedge clk);
        pixel_y = 10'(y);
        pixel_x = 10'd0;
        @(negedge clk);
        pixel_x = 10'd5;
    endtask

    task automatic look(input string tag, input int x, input int y, input logic [15:0] exp);
        @(negedge clk);
        pixel_x = 10'(x);
        pixel_y = 10'(y);
        #1;
        check_eq(tag, 32'(pixel_out), 32'(exp));
    endtask

    task automatic wait_rv(input string tag, input int target, input int budget);
        int cyc;
        cyc = 0;
        while (n_rv < target && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check_eq(tag, 32'(n_rv), 32'(target));
        repeat (3) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int cyc;
        int exp_un;

`ifdef FB_FETCH_UNDERRUN_EN
        exp_un = 1;
`else
        exp_un = 0;
`endif

        reset   = 1'b1;
        pixel_x = 10'd5;
        pixel_y = 10'd0;
        repeat (3) @(negedge clk);

        // reset state
        #1;
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_addr", 32'(mem_addr), 32'd0);
        check_eq("rst_underrun", 32'(underrun_cnt), 32'd0);
        look("rst_pixel", 70, 0, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // frame preload: row 0 -> bank0
        base = n_rv;
        expect_row(0);
        fire(524);
        wait_rv("row0_done", base + 8, 200);
        check_addrs("row0_addr");
        look("row0_w1", 70, 0, 16'hA001);
        look("row0_w0", 0, 7, 16'hA000);
        look("row0_w7", 511, 3, 16'hA007);
        look("bank1_invalid", 70, 8, 16'h0000);

        // y=0 prefetches row 1 into bank1
        base = n_rv;
        expect_row(1);
        fire(0);
        wait_rv("row1_done", base + 8, 200);
        check_addrs("row1_addr");
        look("row1_w1", 70, 8, 16'hA009);
        look("row1_w7", 500, 15, 16'hA00F);
        look("row0_keep", 130, 3, 16'hA002);

        // y=8 prefetches row 2 into bank0; bank0 invalid during the fetch
        base = n_rv;
        expect_row(2);
        fire(8);
        look("bank0_refill", 70, 0, 16'h0000);
        wait_rv("row2_done", base + 8, 200);
        check_addrs("row2_addr");
        look("row2_w1", 64, 16, 16'hA011);
        look("row1_on_bank1", 200, 12, 16'hA00B);

        // bitmap boundaries
        look("x600_y100", 600, 100, 16'h0000);
        look("x10_y400", 10, 400, 16'h0000);
        look("x512_edge", 512, 16, 16'h0000);
        look("x511_edge", 511, 16, 16'hA017);
        look("y383_edge", 0, 383, 16'hA008);
        look("y384_edge", 0, 384, 16'h0000);

        // last row: no fetch beyond ROWS-1
        base = n_gnt;
        fire(376);
        repeat (20) @(negedge clk);
        check_eq("no_row48", 32'(n_gnt), 32'(base));
        base = n_rv;
        expect_row(47);
        fire(368);
        wait_rv("row47_done", base + 8, 200);
        check_addrs("row47_addr");
        look("row47_w0", 10, 376, 16'hA178);

        // slow memory: second trigger hits a busy fetcher
        rv_lat = 200;
        base   = n_rv;
        expect_row(3);
        fire(16);
        repeat (10) @(negedge clk);
        fire(24);
        wait_rv("slow_done", base + 8, 3000);
        base = n_gnt;
        repeat (20) @(negedge clk);
        check_eq("slow_no_extra", 32'(n_gnt), 32'(base));
        check_addrs("slow_addr");
        check_eq("underrun", 32'(underrun_cnt), 32'(exp_un));
        look("row3_w1", 100, 24, 16'hA019);
        look("row2_kept", 64, 16, 16'hA011);

        // reset during WAIT of word 3
        rv_lat = 6;
        base   = n_gnt;
        expect_row(0);
        for (int i = 0; i < 4; i++) void'(exp_q.pop_back());
        fire(524);
        cyc = 0;
        while (n_gnt < base + 4 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rst_wait_gnt", 32'(n_gnt), 32'(base + 4));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("midrst_req", 32'(mem_req), 32'd0);
        check_eq("midrst_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_rv("late_rvalid", base + 4, 200);
        repeat (10) @(negedge clk);
        check_eq("midrst_no_req", 32'(n_gnt), 32'(base + 4));
        check_addrs("midrst_addr_log");
        check_eq("midrst_underrun", 32'(underrun_cnt), 32'd0);
        look("midrst_bank0", 70, 0, 16'h0000);
        look("midrst_bank1", 70, 8, 16'h0000);

        // next completed fetch restores the display
        rv_lat = 2;
        base   = n_rv;
        expect_row(0);
        fire(524);
        wait_rv("refetch_done", base + 8, 200);
        check_addrs("refetch_addr");
        look("refetch_w1", 70, 0, 16'hA001);

        // grant held off for 10 cycles per request
        gnt_lat = 10;
        base    = n_rv;
        expect_row(1);
        fire(0);
        wait_rv("slowgnt_done", base + 8, 400);
        check_addrs("slowgnt_addr");
        look("slowgnt_w1", 70, 8, 16'hA009);
        look("slowgnt_bank0", 70, 0, 16'hA001);
        check_eq("addr_hold", 32'(hold_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fb_fetch
